traffic_phase_ctrl: RTL and testbench

Parametrised single-approach traffic-light sequencer with internal phase timer, configurable green-blink sequence, priority pass request and timer hold. It generates the registered R/G/Y lamp drives plus a phase code and phase-start strobe for the lamp driver and the status logger. Phase lengths and blink count are parameters, not fixed constants. No external counter is used; the block owns its timer.

---
 rtl/traffic_phase_ctrl.sv | 143 ++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
// Single-approach traffic-light sequencer: SG -> blink pairs -> Y -> R, with pass/hold.
// Optional night flash (NOFF/NON) is enabled by defining TRAFFIC_NIGHT_FLASH_EN.
module traffic_phase_ctrl #(
  parameter int CNT_W   = 11,
  parameter int SG_T    = 1024,
  parameter int BLINK_T = 128,
  parameter int BLINK_N = 2,
  parameter int Y_T     = 512,
  parameter int R_T     = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pass,
  input  logic       hold,
`ifdef TRAFFIC_NIGHT_FLASH_EN
  input  logic       night,
`endif
  output logic       R,
  output logic       G,
  output logic       Y,
  output logic [2:0] phase,
  output logic       phase_start
);

  typedef enum logic [2:0] {
    ST_SG   = 3'd0,
    ST_BOFF = 3'd1,
    ST_BON  = 3'd2,
    ST_Y    = 3'd3,
    ST_R    = 3'd4,
    ST_NOFF = 3'd5,
    ST_NON  = 3'd6
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  state_t           succ_s;
  logic [CNT_W-1:0] tmr_r;
  logic [3:0]       bcnt_r;
  logic             expire_s;
  logic             enter_s;
  logic             legal_s;
  logic             pass_ok_s;

  // Terminal timer value of each state: the state exits on the edge where tmr equals it.
  function automatic logic [CNT_W-1:0] last_tick(input state_t s);
    case (s)
      ST_SG:                      last_tick = CNT_W'(SG_T - 1);
      ST_BOFF, ST_BON:            last_tick = CNT_W'(BLINK_T - 1);
      ST_Y:                       last_tick = CNT_W'(Y_T - 1);
      ST_R:                       last_tick = CNT_W'(R_T - 1);
      ST_NOFF, ST_NON:            last_tick = CNT_W'(BLINK_T - 1);
      default:                    last_tick = {CNT_W{1'b0}};
    endcase
  endfunction

  // Successor selection and transition priority: illegal code, then pass, then expiry.
  always_comb begin
    succ_s    = ST_SG;
    legal_s   = 1'b1;
    pass_ok_s = 1'b1;
    expire_s  = (tmr_r == last_tick(state_r)) && !hold;
    case (state_r)
      ST_SG: begin
        succ_s    = ST_BOFF;
        pass_ok_s = 1'b0;
      end
      ST_BOFF: succ_s = ST_BON;
      ST_BON:  succ_s = ((bcnt_r + 4'd1) < 4'(BLINK_N)) ? ST_BOFF : ST_Y;
      ST_Y:    succ_s = ST_R;
`ifdef TRAFFIC_NIGHT_FLASH_EN
      ST_R:    succ_s = night ? ST_NOFF : ST_SG;
      ST_NOFF: begin
        succ_s    = night ? ST_NON : ST_R;
        pass_ok_s = 1'b0;
      end
      ST_NON: begin
        succ_s    = night ? ST_NOFF : ST_R;
        pass_ok_s = 1'b0;
      end
`else
      ST_R:    succ_s = ST_SG;
`endif
      default: begin
        succ_s  = ST_SG;
        legal_s = 1'b0;
      end
    endcase

    if (!legal_s) begin
      state_nxt_s = ST_SG;
      enter_s     = 1'b1;
    end else if (pass && pass_ok_s) begin
      state_nxt_s = ST_SG;
      enter_s     = 1'b1;
    end else if (expire_s) begin
      state_nxt_s = succ_s;
      enter_s     = 1'b1;
    end else begin
      state_nxt_s = state_r;
      enter_s     = 1'b0;
    end
  end

  // State, timer, blink counter and lamp outputs all decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_SG;
      tmr_r       <= {CNT_W{1'b0}};
      bcnt_r      <= 4'd0;
      R           <= 1'b0;
      G           <= 1'b1;
      Y           <= 1'b0;
      phase       <= 3'd0;
      phase_start <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      phase       <= 3'(state_nxt_s);
      R           <= (state_nxt_s == ST_R);
      G           <= (state_nxt_s == ST_SG) || (state_nxt_s == ST_BON);
      Y           <= (state_nxt_s == ST_Y) || (state_nxt_s == ST_NON);
      phase_start <= enter_s;

      if (enter_s) begin
        tmr_r <= {CNT_W{1'b0}};
      end else if (!hold) begin
        tmr_r <= tmr_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        tmr_r <= tmr_r;
      end

      // A BON exit completes one blink pair unless it is a pass back to SG.
      if (enter_s && (state_nxt_s == ST_SG)) begin
        bcnt_r <= 4'd0;
      end else if (enter_s && (state_r == ST_BON)) begin
        bcnt_r <= bcnt_r + 4'd1;
      end else begin
        bcnt_r <= bcnt_r;
      end
    end
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: directed timeline checks plus randomized
// pass/hold/reset traffic against a countdown-based phase model.
module tb_traffic_phase_ctrl;

  localparam int CNT_W   = 4;
  localparam int SG_T    = 8;
  localparam int BLINK_T = 2;
  localparam int BLINK_N = 2;
  localparam int Y_T     = 4;
  localparam int R_T     = 8;
`ifdef TRAFFIC_NIGHT_FLASH_EN
  localparam bit NIGHT_EN = 1'b1;
`else
  localparam bit NIGHT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pass = 1'b0;
  logic       hold = 1'b0;
  logic       night = 1'b0;
  logic       R, G, Y, phase_start;
  logic [2:0] phase;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  int   m_ph = 0;
  int   m_rem = SG_T;
  int   m_pairs = 0;
  logic m_ps = 1'b1;

  always #5 clk = ~clk;

  traffic_phase_ctrl #(
    .CNT_W(CNT_W), .SG_T(SG_T), .BLINK_T(BLINK_T), .BLINK_N(BLINK_N), .Y_T(Y_T), .R_T(R_T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pass(pass),
    .hold(hold),
`ifdef TRAFFIC_NIGHT_FLASH_EN
    .night(night),
`endif
    .R(R),
    .G(G),
    .Y(Y),
    .phase(phase),
    .phase_start(phase_start)
  );

  function automatic int dur(input int ph);
    case (ph)
      0:       return SG_T;
      3:       return Y_T;
      4:       return R_T;
      default: return BLINK_T;
    endcase
  endfunction

  task automatic enter(input int ph);
    m_ph  = ph;
    m_rem = dur(ph);
    m_ps  = 1'b1;
    if (ph == 0) m_pairs = 0;
  endtask

  // Reference: each phase holds a countdown of remaining cycles; leaves when one remains.
  task automatic model_update(input logic p, input logic h, input logic n, input logic r);
    int nx;
    if (r) begin
      enter(0);
    end else if (p && m_ph != 0 && m_ph < 5) begin
      enter(0);
    end else if (h) begin
      m_ps = 1'b0;
    end else if (m_rem == 1) begin
      case (m_ph)
        0: nx = 1;
        1: nx = 2;
        2: begin
          m_pairs = m_pairs + 1;
          nx = (m_pairs < BLINK_N) ? 1 : 3;
        end
        3: nx = 4;
        4: nx = (NIGHT_EN && n) ? 5 : 0;
        5: nx = n ? 6 : 4;
        default: nx = n ? 5 : 4;
      endcase
      enter(nx);
    end else begin
      m_rem = m_rem - 1;
      m_ps  = 1'b0;
    end
  endtask

  function automatic logic [6:0] model_vec();
    logic [2:0] ph3;
    ph3 = 3'(m_ph);
    return {(m_ph == 4), (m_ph == 0 || m_ph == 2), (m_ph == 3 || m_ph == 6), ph3, m_ps};
  endfunction

  task automatic tick(input logic p, input logic h, input logic n, input logic r);
    pass  = p;
    hold  = h;
    night = n;
    rst   = r;
    @(posedge clk);
    #1;
    model_update(p, h, n, r);
    cyc = r ? 0 : cyc + 1;
  endtask

  task automatic test_reset();
    logic [6:0] got;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    got = {R, G, Y, phase, phase_start};
    n_cmp++;
    if (got !== 7'b010_000_1) begin
      n_fail++;
      $display("FAIL reset_state cycle %0d: got %b want %b", cyc, got, 7'b010_000_1);
    end
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    got = {R, G, Y, phase, phase_start};
    n_cmp++;
    if (got !== 7'b010_000_1) begin
      n_fail++;
      $display("FAIL reset_over_pass cycle %0d: got %b want %b", cyc, got, 7'b010_000_1);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    got = {R, G, Y, phase, phase_start};
    n_cmp++;
    if (got !== 7'b010_000_0) begin
      n_fail++;
      $display("FAIL reset_second_cycle cycle %0d: got %b want %b", cyc, got, 7'b010_000_0);
    end
  endtask

  task automatic test_baseline();
    logic [6:0] got, exp;
    logic [2:0] eph;
    logic       eps;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c <= 29; c++) begin
      if (c < 8)       eph = 3'd0;
      else if (c < 10) eph = 3'd1;
      else if (c < 12) eph = 3'd2;
      else if (c < 14) eph = 3'd1;
      else if (c < 16) eph = 3'd2;
      else if (c < 20) eph = 3'd3;
      else if (c < 28) eph = 3'd4;
      else             eph = 3'd0;
      eps = (c == 0 || c == 8 || c == 10 || c == 12 || c == 14 || c == 16 || c == 20 || c == 28);
      exp = {(eph == 3'd4), (eph == 3'd0 || eph == 3'd2), (eph == 3'd3), eph, eps};
      got = {R, G, Y, phase, phase_start};
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL baseline cycle %0d: got %b want %b", c, got, exp);
      end
      tick(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_pass();
    logic [6:0] got;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c <= 35; c++) begin
      got = {R, G, Y, phase, phase_start};
      n_cmp++;
      if (got !== model_vec()) begin
        n_fail++;
        $display("FAIL pass_model cycle %0d: got %b want %b", c, got, model_vec());
      end
      if (c == 8 || c == 18 || c == 34) begin
        n_cmp++;
        if (got !== ((c == 34) ? 7'b001_011_1 : (c == 18) ? 7'b010_000_1 : 7'b000_001_1)) begin
          n_fail++;
          $display("FAIL pass_timeline cycle %0d: got %b", c, got);
        end
      end
      tick((c == 3) || (c == 17), 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_hold();
    logic [6:0] got;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c <= 34; c++) begin
      got = {R, G, Y, phase, phase_start};
      n_cmp++;
      if (got !== model_vec()) begin
        n_fail++;
        $display("FAIL hold_model cycle %0d: got %b want %b", c, got, model_vec());
      end
      if (c == 32 || c == 33) begin
        n_cmp++;
        if (got !== ((c == 32) ? 7'b100_100_0 : 7'b010_000_1)) begin
          n_fail++;
          $display("FAIL hold_timeline cycle %0d: got %b", c, got);
        end
      end
      tick(1'b0, (c >= 21 && c <= 25), 1'b0, 1'b0);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c <= 26; c++) begin
      got = {R, G, Y, phase, phase_start};
      n_cmp++;
      if (got !== model_vec()) begin
        n_fail++;
        $display("FAIL hold_pass_model cycle %0d: got %b want %b", c, got, model_vec());
      end
      if (c == 24) begin
        n_cmp++;
        if (got !== 7'b010_000_1) begin
          n_fail++;
          $display("FAIL hold_pass_timeline cycle %0d: got %b want %b", c, got, 7'b010_000_1);
        end
      end
      tick((c == 23), (c >= 21 && c <= 25), 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] got;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c <= 18; c++) tick(1'b0, 1'b0, 1'b0, (c == 18));
    for (int c = 0; c <= 9; c++) begin
      got = {R, G, Y, phase, phase_start};
      n_cmp++;
      if (got !== model_vec()) begin
        n_fail++;
        $display("FAIL reset_mid_model cycle %0d: got %b want %b", c, got, model_vec());
      end
      if (c == 0 || c == 8) begin
        n_cmp++;
        if (got !== ((c == 0) ? 7'b010_000_1 : 7'b000_001_1)) begin
          n_fail++;
          $display("FAIL reset_mid_timeline cycle %0d: got %b", c, got);
        end
      end
      tick(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

`ifdef TRAFFIC_NIGHT_FLASH_EN
  task automatic test_night();
    logic [6:0] got, exp;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c <= 44; c++) begin
      got = {R, G, Y, phase, phase_start};
      n_cmp++;
      if (got !== model_vec()) begin
        n_fail++;
        $display("FAIL night_model cycle %0d: got %b want %b", c, got, model_vec());
      end
      if (c == 28 || c == 30 || c == 32 || c == 34 || c == 42) begin
        case (c)
          28:      exp = 7'b000_101_1;
          30:      exp = 7'b001_110_1;
          32:      exp = 7'b000_101_1;
          34:      exp = 7'b100_100_1;
          default: exp = 7'b010_000_1;
        endcase
        n_cmp++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL night_timeline cycle %0d: got %b want %b", c, got, exp);
        end
      end
      tick((c == 29), 1'b0, (c >= 20 && c < 32), 1'b0);
    end
  endtask
`endif

  task automatic test_random();
    logic [6:0] got;
    logic       n_lvl;
    n_lvl = 1'b0;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      if (NIGHT_EN && $urandom_range(0, 39) == 0) n_lvl = ~n_lvl;
      tick(($urandom_range(0, 24) == 0), ($urandom_range(0, 7) == 0), n_lvl,
           ($urandom_range(0, 699) == 0));
      got = {R, G, Y, phase, phase_start};
      n_cmp++;
      if (got !== model_vec()) begin
        n_fail++;
        $display("FAIL random step %0d: got %b want %b", i, got, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_baseline();
    test_pass();
    test_hold();
    test_reset_mid();
`ifdef TRAFFIC_NIGHT_FLASH_EN
    test_night();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
